// File: rtl/pipe_pkg.sv
// Shared encodings for the EXE stage: ALU op codes, multiply/divide op codes
// and the multi-cycle sequencer states.
package pipe_pkg;
   // ALU codes; bit 3 only distinguishes SRA from SRL
   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;

   typedef enum logic [1:0] {
      MD_NONE = 2'b00,
      MD_MUL  = 2'b01,
      MD_DIVU = 2'b10,
      MD_REMU = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } md_state_e;
endpackage

// File: rtl/alu.sv
// Single-cycle ALU: add/sub, logic ops, LUI and the three shifts (shift amount in a).
module alu #(
   parameter int WIDTH = 32,
   parameter int SAW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       aluc,
   output logic [WIDTH-1:0] r
);
   // Decode on the low three bits; bit 3 picks arithmetic vs logical right shift
   always_comb begin
      r = '0;
      case (aluc[2:0])
         3'b000: r = a + b;
         3'b100: r = a - b;
         3'b001: r = a & b;
         3'b101: r = a | b;
         3'b010: r = a ^ b;
         3'b110: r = b << 16;
         3'b011: r = b << a[SAW-1:0];
         default: begin
            if (aluc[3]) r = $signed(b) >>> a[SAW-1:0];
            else         r = b >> a[SAW-1:0];
         end
      endcase
   end
endmodule

// File: rtl/md_iter.sv
// Iterative multiply / unsigned divide, one bit per cycle, with its own
// IDLE/BUSY/DONE sequencer. Registers are shared between the two ops:
// MUL: acc=partial sum, x=shifted multiplicand, y=remaining multiplier.
// DIV: acc=partial remainder, x=divisor, y=dividend shifting out / quotient shifting in.
module md_iter
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int REGW  = 5,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic             ack,
   input  md_op_e           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [REGW-1:0]  rn_in,
   output md_state_e        state,
   output logic [WIDTH-1:0] res,
   output logic [REGW-1:0]  rn,
   output logic             div0
);
   logic [CW-1:0]    cnt;
   md_op_e           op_q;
   logic [WIDTH-1:0] acc, x, y;
   logic [WIDTH-1:0] acc_n, x_n, y_n, sum;
   logic [WIDTH:0]   tmp, diff;
   logic             ge;

   // One iteration step for whichever op is latched
   always_comb begin
      sum  = acc + x;
      tmp  = {acc, y[WIDTH-1]};
      diff = tmp - {1'b0, x};
      ge   = ~diff[WIDTH];
      if (op_q == MD_MUL) begin
         acc_n = y[0] ? sum : acc;
         x_n   = x << 1;
         y_n   = y >> 1;
      end else begin
         acc_n = ge ? diff[WIDTH-1:0] : tmp[WIDTH-1:0];
         x_n   = x;
         y_n   = {y[WIDTH-2:0], ge};
      end
   end

   // Sequencer: issue, iterate WIDTH steps, hold result until accepted
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= MD_NONE;
         acc   <= '0;
         x     <= '0;
         y     <= '0;
         res   <= '0;
         rn    <= '0;
         div0  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_q <= op;
               rn   <= rn_in;
               cnt  <= CW'(WIDTH - 1);
               acc  <= '0;
               // zero divisor skips iteration entirely
               if (op != MD_MUL && b == '0) begin
                  state <= S_DONE;
                  div0  <= 1'b1;
                  res   <= (op == MD_DIVU) ? '1 : a;
               end else begin
                  state <= S_BUSY;
                  div0  <= 1'b0;
                  x     <= (op == MD_MUL) ? a : b;
                  y     <= (op == MD_MUL) ? b : a;
               end
            end
            S_BUSY: begin
               acc <= acc_n;
               x   <= x_n;
               y   <= y_n;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state <= S_DONE;
                  res   <= (op_q == MD_DIVU) ? y_n : acc_n;
               end
            end
            S_DONE: if (ack) begin
               state <= S_IDLE;
               div0  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/mux2x32.sv
// Two-input word mux.
module mux2x32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);
   assign y = s ? a1 : a0;
endmodule

// File: rtl/pipe_exe_md.sv
// EXE stage with single-cycle ALU/JAL path and a multi-cycle multiply/divide
// unit that stalls the front end until its result is taken by EXE/MEM.
module pipe_exe_md
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int REGW  = 5,
   parameter int SAW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             ein_valid,
   input  logic [3:0]       ealuc,
   input  logic             ealuimm,
   input  logic             eshift,
   input  logic             ejal,
   input  logic [1:0]       emd_op,
   input  logic [WIDTH-1:0] ea,
   input  logic [WIDTH-1:0] eb,
   input  logic [WIDTH-1:0] eimm,
   input  logic [WIDTH-1:0] epc4,
   input  logic [REGW-1:0]  ern0,
   input  logic             mem_ready,
   output logic [WIDTH-1:0] ealu,
   output logic [REGW-1:0]  ern,
   output logic             eout_valid,
   output logic             estall,
   output logic             ediv0
);
   logic [WIDTH-1:0] sa, alua, alub, alur, epc8, fast;
   logic [WIDTH-1:0] md_res;
   logic [REGW-1:0]  md_rn;
   logic             md_div0, is_md, start;
   md_state_e        state;

   assign sa    = {{(WIDTH-SAW){1'b0}}, eimm[6+SAW-1:6]};
   assign epc8  = epc4 + WIDTH'(4);
   assign is_md = (emd_op != MD_NONE) && !ejal;
   assign start = ein_valid && is_md && (state == S_IDLE);

   mux2x32 #(.WIDTH(WIDTH)) u_mux_a   (.a0(ea),   .a1(sa),   .s(eshift),  .y(alua));
   mux2x32 #(.WIDTH(WIDTH)) u_mux_b   (.a0(eb),   .a1(eimm), .s(ealuimm), .y(alub));
   alu     #(.WIDTH(WIDTH), .SAW(SAW)) u_alu (.a(alua), .b(alub), .aluc(ealuc), .r(alur));
   mux2x32 #(.WIDTH(WIDTH)) u_mux_jal (.a0(alur), .a1(epc8), .s(ejal),    .y(fast));

   md_iter #(.WIDTH(WIDTH), .REGW(REGW)) u_md (
      .clock (clock),
      .resetn(resetn),
      .start (start),
      .ack   (mem_ready),
      .op    (md_op_e'(emd_op)),
      .a     (alua),
      .b     (alub),
      .rn_in (ern0),
      .state (state),
      .res   (md_res),
      .rn    (md_rn),
      .div0  (md_div0)
   );

   // Output select and handshake; everything forced quiet while in reset
   always_comb begin
      ealu       = fast;
      ern        = ern0 | {REGW{ejal}};
      eout_valid = 1'b0;
      estall     = 1'b0;
      ediv0      = 1'b0;
      case (state)
         S_IDLE: begin
            eout_valid = ein_valid && !is_md;
            estall     = ein_valid && (is_md || !mem_ready);
         end
         S_BUSY: estall = 1'b1;
         S_DONE: begin
            ealu       = md_res;
            ern        = md_rn;
            eout_valid = 1'b1;
            estall     = !mem_ready;
            ediv0      = md_div0;
         end
         default: ;
      endcase
      if (!resetn) begin
         eout_valid = 1'b0;
         estall     = 1'b0;
         ediv0      = 1'b0;
      end
   end
endmodule

// File: tb/tb_pipe_exe_md.sv
// Directed bench for pipe_exe_md (WIDTH=32) with a queue of expected MD results.
module tb_pipe_exe_md;
   import pipe_pkg::*;
   localparam int W = 32;

   logic          clock = 1'b0;
   logic          resetn;
   logic          ein_valid, ealuimm, eshift, ejal, mem_ready;
   logic [3:0]    ealuc;
   logic [1:0]    emd_op;
   logic [W-1:0]  ea, eb, eimm, epc4;
   logic [4:0]    ern0;
   logic [W-1:0]  ealu;
   logic [4:0]    ern;
   logic          eout_valid, estall, ediv0;

   always #5 clock = ~clock;

   pipe_exe_md #(.WIDTH(W), .REGW(5)) dut (
      .clock(clock), .resetn(resetn), .ein_valid(ein_valid), .ealuc(ealuc),
      .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .emd_op(emd_op),
      .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
      .mem_ready(mem_ready), .ealu(ealu), .ern(ern), .eout_valid(eout_valid),
      .estall(estall), .ediv0(ediv0)
   );

   typedef struct {
      logic [W-1:0] alu;
      logic [4:0]   rn;
      logic         div0;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic idle_inputs();
      ein_valid = 0; ealuc = ALUC_ADD; ealuimm = 0; eshift = 0; ejal = 0;
      emd_op = MD_NONE; ea = '0; eb = '0; eimm = '0; epc4 = '0; ern0 = '0;
      mem_ready = 1;
   endtask

   task automatic test_reset();
      resetn = 0;
      idle_inputs();
      ein_valid = 1; ealuimm = 1; ea = 5; eimm = 7;
      #2;
      checks++;
      if (eout_valid !== 1'b0 || estall !== 1'b0 || ediv0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b s=%b d=%b want 0 0 0", eout_valid, estall, ediv0);
      end
      repeat (2) @(posedge clock);
      #1 resetn = 1; ein_valid = 0;
      #1;
      checks++;
      if (eout_valid !== 1'b0 || estall !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got v=%b s=%b want 0 0", eout_valid, estall);
      end
   endtask

   // Single-cycle op: result in the same cycle, stall only when EXE/MEM is full
   task automatic test_alu_op(input string nm, input logic [3:0] c, input logic imm,
                              input logic sh, input logic jal, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] im,
                              input logic [W-1:0] pc4, input logic [4:0] rn,
                              input logic [W-1:0] xalu, input logic [4:0] xrn);
      @(posedge clock); #1;
      idle_inputs();
      ein_valid = 1; ealuc = c; ealuimm = imm; eshift = sh; ejal = jal;
      ea = a; eb = b; eimm = im; epc4 = pc4; ern0 = rn;
      emd_op = jal ? MD_MUL : MD_NONE;   // jal must override any md op
      #1;
      checks++;
      if (ealu !== xalu || ern !== xrn || eout_valid !== 1'b1 || estall !== 1'b0) begin
         errors++;
         $display("FAIL %s: got alu=%h rn=%0d v=%b s=%b want alu=%h rn=%0d v=1 s=0",
                  nm, ealu, ern, eout_valid, estall, xalu, xrn);
      end
      mem_ready = 0;
      #1;
      checks++;
      if (estall !== 1'b1 || eout_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_stall: got s=%b v=%b want s=1 v=1", nm, estall, eout_valid);
      end
      @(posedge clock); #1;
      idle_inputs();
   endtask

   task automatic test_alu();
      test_alu_op("add_imm", ALUC_ADD, 1, 0, 0, 32'd5, 32'd0, 32'd7, 32'd0, 5'd3, 32'd12, 5'd3);
      test_alu_op("sll", ALUC_SLL, 0, 1, 0, 32'd0, 32'd1, 32'h000000C0, 32'd0, 5'd4, 32'd8, 5'd4);
      test_alu_op("jal", ALUC_ADD, 0, 0, 1, 32'd1, 32'd2, 32'd0, 32'h100, 5'd0, 32'h104, 5'd31);
      test_alu_op("sub", ALUC_SUB, 0, 0, 0, 32'd10, 32'd3, 32'd0, 32'd0, 5'd7, 32'd7, 5'd7);
      test_alu_op("sra", ALUC_SRA, 0, 1, 0, 32'd0, 32'h80000000, 32'h00000100, 32'd0, 5'd8,
                  32'hF8000000, 5'd8);
   endtask

   // Issue one MD op, hold it in DONE for 'hold' cycles, then accept it
   task automatic run_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rn, input int hold);
      exp_t e;
      int   edges, stalls;
      bit   done;
      e.rn = rn; e.div0 = 0; e.lat = W + 1;
      case (op)
         MD_MUL:  e.alu = a * b;
         MD_DIVU: if (b == 0) begin e.alu = '1; e.div0 = 1; e.lat = 1; end else e.alu = a / b;
         default: if (b == 0) begin e.alu = a;  e.div0 = 1; e.lat = 1; end else e.alu = a % b;
      endcase
      sb.push_back(e);
      idle_inputs();
      ein_valid = 1; emd_op = op; ea = a; eb = b; ern0 = rn; mem_ready = (hold == 0);
      #1;
      checks++;
      if (eout_valid !== 1'b0 || estall !== 1'b1) begin
         errors++;
         $display("FAIL md_issue: got v=%b s=%b want v=0 s=1", eout_valid, estall);
      end
      stalls = (estall === 1'b1) ? 1 : 0;
      edges = 0; done = 0;
      while (!done && edges < 200) begin
         @(posedge clock); #1;
         edges++;
         // operands must be latched; scribble over them while busy
         ea = $urandom; eb = $urandom; ern0 = 5'($urandom);
         #1;
         if (eout_valid === 1'b1) done = 1;
         else if (estall === 1'b1) stalls++;
      end
      e = sb.pop_front();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL md_timeout: got no eout_valid after %0d edges want %0d", edges, e.lat);
      end else begin
         checks++;
         if (edges != e.lat || stalls != e.lat) begin
            errors++;
            $display("FAIL md_latency: got edges=%0d stalls=%0d want %0d", edges, stalls, e.lat);
         end
         checks++;
         if (ealu !== e.alu || ern !== e.rn || ediv0 !== e.div0) begin
            errors++;
            $display("FAIL md_result: got alu=%h rn=%0d d=%b want alu=%h rn=%0d d=%b",
                     ealu, ern, ediv0, e.alu, e.rn, e.div0);
         end
         for (int h = 0; h < hold; h++) begin
            checks++;
            if (estall !== 1'b1 || eout_valid !== 1'b1 || ealu !== e.alu) begin
               errors++;
               $display("FAIL md_hold: got s=%b v=%b alu=%h want s=1 v=1 alu=%h",
                        estall, eout_valid, ealu, e.alu);
            end
            @(posedge clock); #2;
         end
         mem_ready = 1;
         #1;
         checks++;
         if (estall !== 1'b0 || eout_valid !== 1'b1) begin
            errors++;
            $display("FAIL md_accept: got s=%b v=%b want s=0 v=1", estall, eout_valid);
         end
      end
      @(posedge clock); #1;
      idle_inputs();
      #1;
      checks++;
      if (eout_valid !== 1'b0 || estall !== 1'b0) begin
         errors++;
         $display("FAIL md_release: got v=%b s=%b want 0 0", eout_valid, estall);
      end
   endtask

   task automatic test_mul();
      run_md(MD_MUL, 32'h0000FFFF, 32'h00010001, 5'd10, 0);
      run_md(MD_MUL, $urandom, $urandom, 5'd11, 0);
   endtask

   task automatic test_back_to_back();
      run_md(MD_DIVU, 32'd100, 32'd7, 5'd12, 0);
      run_md(MD_REMU, 32'd100, 32'd7, 5'd13, 0);
      run_md(MD_DIVU, 32'hFFFFFFFF, 32'd3, 5'd14, 0);
      run_md(MD_REMU, $urandom, 32'($urandom_range(1, 1000)), 5'd15, 0);
   endtask

   task automatic test_div0();
      run_md(MD_DIVU, 32'd9, 32'd0, 5'd16, 0);
      run_md(MD_REMU, 32'd9, 32'd0, 5'd17, 0);
   endtask

   task automatic test_hold();
      run_md(MD_MUL, 32'd1234, 32'd5678, 5'd18, 3);
   endtask

   task automatic test_reset_midbusy();
      @(posedge clock); #1;
      idle_inputs();
      ein_valid = 1; emd_op = MD_MUL; ea = 3; eb = 4; ern0 = 5'd19;
      repeat (10) @(posedge clock);
      #1 resetn = 0;
      #1;
      checks++;
      if (eout_valid !== 1'b0 || estall !== 1'b0 || ediv0 !== 1'b0) begin
         errors++;
         $display("FAIL midbusy_reset: got v=%b s=%b d=%b want 0 0 0", eout_valid, estall, ediv0);
      end
      @(posedge clock); #1;
      resetn = 1; idle_inputs();
      #1;
      checks++;
      if (eout_valid !== 1'b0 || estall !== 1'b0) begin
         errors++;
         $display("FAIL midbusy_idle: got v=%b s=%b want 0 0", eout_valid, estall);
      end
      run_md(MD_MUL, 32'd6, 32'd7, 5'd20, 0);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mul();
      test_back_to_back();
      test_div0();
      test_hold();
      test_reset_midbusy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
